inst_mem_loader: RTL

Writer side of the instruction memory. Assembles a byte stream (host/UART side) into 32-bit instruction words and writes them sequentially into the 64-word instruction RAM through its write port, starting at word 0. The PC/fetch path reads this RAM through its read port. The loader holds the CPU in reset while loading, so fetch starts at address 0 only after the program image is complete.

---
 rtl/inst_loader_pkg.sv | 15 +
 rtl/inst_mem_loader_byte_packer.sv | 43 ++++
 rtl/inst_mem_loader.sv | 131 +++++++++++++
 3 files changed

// File: rtl/inst_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
// The CHK state is only reached when the build defines CHECKSUM_EN.
package inst_loader_pkg;
    localparam int INST_W         = 32;
    localparam int BYTES_PER_WORD = 4;
    localparam int LANE_W         = $clog2(BYTES_PER_WORD);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        WRITE,
        CHK,
        DONE
    } loader_state_e;
endpackage

// File: rtl/inst_mem_loader_byte_packer.sv
// Byte-to-word assembler: lane counter plus assembly register.
// BYTE_LE selects whether the first byte of a word lands in bits [31:24] or [7:0].
module byte_packer
    import inst_loader_pkg::*;
#(
    parameter int BYTE_LE = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              byte_en,
    input  logic [7:0]        byte_in,
    output logic [INST_W-1:0] word_next,
    output logic              word_full
);
    logic [LANE_W-1:0]                lane_q;
    logic [BYTES_PER_WORD-1:0][7:0]   asm_q;
    logic [BYTES_PER_WORD-1:0][7:0]   asm_d;

    // word_next includes the byte being accepted, so the top can capture a
    // complete word on the same edge as the 4th transfer.
    for (genvar i = 0; i < BYTES_PER_WORD; i++) begin : g_lane
        localparam logic [LANE_W-1:0] K = (BYTE_LE != 0) ? LANE_W'(i)
                                                          : LANE_W'(BYTES_PER_WORD - 1 - i);
        assign asm_d[i] = (byte_en && lane_q == K) ? byte_in : asm_q[i];
    end

    assign word_next = asm_d;
    assign word_full = byte_en && (lane_q == LANE_W'(BYTES_PER_WORD - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            lane_q <= '0;
            asm_q  <= '0;
        end else begin
            asm_q <= asm_d;
            if (clear)
                lane_q <= '0;
            else if (byte_en)
                lane_q <= lane_q + LANE_W'(1);
        end
    end
endmodule

// File: rtl/inst_mem_loader.sv
// Streams bytes into 32-bit words and writes them to instruction RAM from word 0,
// holding the CPU in reset meanwhile. Define CHECKSUM_EN for the trailing checksum byte.
module inst_mem_loader
    import inst_loader_pkg::*;
#(
    parameter int ADDR_W  = 6,
    parameter int BYTE_LE = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W:0]   len,
    input  logic [7:0]        byte_in,
    input  logic              byte_valid,
    output logic              byte_ready,
    output logic              wea,
    output logic [ADDR_W-1:0] addra,
    output logic [INST_W-1:0] dina,
    output logic              busy,
    output logic              cpu_hold,
    output logic              done,
    output logic [ADDR_W:0]   word_cnt,
    output logic              chk_err
);
    localparam logic [ADDR_W:0] FULL_LEN = (ADDR_W + 1)'(2 ** ADDR_W);

    loader_state_e     state_q, state_d;
    logic [ADDR_W:0]   len_q;
    logic [INST_W-1:0] word_next;
    logic              word_full;
    logic              xfer, load_xfer, start_acc, last_word;

    assign xfer      = byte_valid && byte_ready;
    assign load_xfer = xfer && (state_q == LOAD);
    assign start_acc = start && (state_q == IDLE || state_q == DONE);
    assign last_word = (word_cnt + 1'b1) == len_q;
    assign cpu_hold  = busy;
    assign done      = (state_q == DONE);

    byte_packer #(.BYTE_LE(BYTE_LE)) u_packer (
        .clk      (clk),
        .reset    (reset),
        .clear    (start_acc),
        .byte_en  (load_xfer),
        .byte_in  (byte_in),
        .word_next(word_next),
        .word_full(word_full)
    );

    always_ff @(posedge clk) begin
        if (reset)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d    = state_q;
        byte_ready = 1'b0;
        wea        = 1'b0;
        busy       = 1'b0;
        case (state_q)
            IDLE, DONE: if (start) state_d = LOAD;
            LOAD: begin
                byte_ready = 1'b1;
                busy       = 1'b1;
                if (word_full) state_d = WRITE;
            end
            WRITE: begin
                wea  = 1'b1;
                busy = 1'b1;
`ifdef CHECKSUM_EN
                state_d = last_word ? CHK : LOAD;
`else
                state_d = last_word ? DONE : LOAD;
`endif
            end
`ifdef CHECKSUM_EN
            CHK: begin
                byte_ready = 1'b1;
                busy       = 1'b1;
                if (xfer) state_d = DONE;
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    // dina is captured on the completing byte so it stays stable until the next word.
    always_ff @(posedge clk) begin
        if (reset) begin
            len_q    <= '0;
            addra    <= '0;
            word_cnt <= '0;
            dina     <= '0;
        end else begin
            if (start_acc) begin
                len_q    <= (len == '0) ? FULL_LEN : len;
                addra    <= '0;
                word_cnt <= '0;
            end
            if (word_full)
                dina <= word_next;
            if (state_q == WRITE) begin
                addra    <= addra + 1'b1;
                word_cnt <= word_cnt + 1'b1;
            end
        end
    end

`ifdef CHECKSUM_EN
    logic [7:0] sum_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            sum_q   <= '0;
            chk_err <= 1'b0;
        end else if (start_acc) begin
            sum_q   <= '0;
            chk_err <= 1'b0;
        end else begin
            if (load_xfer)
                sum_q <= sum_q + byte_in;
            if (state_q == CHK && xfer)
                chk_err <= (byte_in != sum_q);
        end
    end
`else
    assign chk_err = 1'b0;
`endif
endmodule
